// File: rtl/ex_ctrl_if.sv
// Purpose: decode->execute->memory handshake and data bundle for ex_ctrl.
// Ports:   in_* / valA/valB/valE / flush from decode and ALU; out_* / cc / stat / halted to memory.
// slave modport is the controller side; master is the surrounding pipeline.
interface ex_ctrl_if #(
  parameter int WIDTH = 32
);
  logic             in_valid_i;
  logic             in_ready_o;
  logic [7:0]       icode_i;
  logic [7:0]       ifun_i;
  logic [WIDTH-1:0] valA_i;
  logic [WIDTH-1:0] valB_i;
  logic [WIDTH-1:0] valE_i;
  logic             flush_i;
  logic             out_valid_o;
  logic             out_ready_i;
  logic [7:0]       icode_o;
  logic [7:0]       ifun_o;
  logic [WIDTH-1:0] valE_o;
  logic             cnd_o;
  logic [2:0]       cc_o;
  logic [1:0]       stat_o;
  logic             halted_o;

  modport slave (
    input  in_valid_i, icode_i, ifun_i, valA_i, valB_i, valE_i, flush_i, out_ready_i,
    output in_ready_o, out_valid_o, icode_o, ifun_o, valE_o, cnd_o, cc_o, stat_o, halted_o
  );

  modport master (
    output in_valid_i, icode_i, ifun_i, valA_i, valB_i, valE_i, flush_i, out_ready_i,
    input  in_ready_o, out_valid_o, icode_o, ifun_o, valE_o, cnd_o, cc_o, stat_o, halted_o
  );
endinterface

// File: rtl/ex_ctrl.sv
// Purpose: Y86 execute-stage controller: EX/MEM register, condition codes, Cnd, HALT state.
// Latency: one cycle from accept to out_valid_o; full throughput when memory consumes every cycle.
// Backpressure: in_ready_o drops while the output register is full and not consumed, on flush, or in HALT.
// Ports: clk, rst (async active-low), bus (ex_ctrl_if.slave) carrying handshake, operands and results.
module ex_ctrl #(
  parameter int         WIDTH    = 32,
  parameter logic [2:0] CC_RESET = 3'b100
) (
  input logic     clk,
  input logic     rst,
  ex_ctrl_if.slave bus
);

  localparam logic [7:0] I_HALT   = 8'h00;
  localparam logic [7:0] I_CMOVXX = 8'h02;
  localparam logic [7:0] I_OPL    = 8'h06;
  localparam logic [7:0] I_JXX    = 8'h07;
  localparam logic [7:0] I_MAX    = 8'h0B;

  typedef enum logic {RUN, HALT} state_e;

  state_e           state_q, state_d;
  logic             valid_q, valid_d;
  logic [7:0]       icode_q, icode_d;
  logic [7:0]       ifun_q, ifun_d;
  logic [WIDTH-1:0] vale_q, vale_d;
  logic             cnd_q, cnd_d;
  logic [2:0]       cc_q, cc_d;      // {ZF,SF,OF}
  logic [1:0]       stat_q, stat_d;

  logic in_ready;
  logic accept;
  logic is_cond;
  logic illegal;
  logic cnd_eval;
  logic zf, sf, of;
  logic a_s, b_s, e_s;

  assign in_ready = (state_q == RUN) && !bus.flush_i && (!valid_q || bus.out_ready_i);
  assign accept   = bus.in_valid_i && in_ready;

  assign is_cond = (bus.icode_i == I_CMOVXX) || (bus.icode_i == I_JXX);
  assign illegal = (bus.icode_i > I_MAX) ||
                   ((bus.icode_i == I_OPL) && (bus.ifun_i > 8'd3)) ||
                   (is_cond && (bus.ifun_i > 8'd6));

  // Condition uses the flags as they stand before this cycle's update.
  always_comb begin
    cnd_eval = 1'b0;
    case (bus.ifun_i)
      8'd0: cnd_eval = 1'b1;
      8'd1: cnd_eval = (cc_q[1] ^ cc_q[0]) | cc_q[2];
      8'd2: cnd_eval = cc_q[1] ^ cc_q[0];
      8'd3: cnd_eval = cc_q[2];
      8'd4: cnd_eval = !cc_q[2];
      8'd5: cnd_eval = !(cc_q[1] ^ cc_q[0]);
      8'd6: cnd_eval = !(cc_q[1] ^ cc_q[0]) && !cc_q[2];
      default: cnd_eval = 1'b0;
    endcase
  end

  assign a_s = bus.valA_i[WIDTH-1];
  assign b_s = bus.valB_i[WIDTH-1];
  assign e_s = bus.valE_i[WIDTH-1];
  assign zf  = (bus.valE_i == '0);
  assign sf  = e_s;

  // subl computes B-A, so overflow is judged against B's sign.
  always_comb begin
    of = 1'b0;
    case (bus.ifun_i)
      8'd0:    of = (a_s == b_s) && (e_s != a_s);
      8'd1:    of = (a_s != b_s) && (e_s != b_s);
      default: of = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    icode_d = icode_q;
    ifun_d  = ifun_q;
    vale_d  = vale_q;
    cnd_d   = cnd_q;
    cc_d    = cc_q;
    stat_d  = stat_q;
    if (accept) begin
      valid_d = 1'b1;
      icode_d = bus.icode_i;
      ifun_d  = bus.ifun_i;
      vale_d  = bus.valE_i;
      cnd_d   = is_cond ? cnd_eval : 1'b0;
      if (illegal) begin
        stat_d  = 2'd2;
        state_d = HALT;
      end else if (bus.icode_i == I_HALT) begin
        stat_d  = 2'd1;
        state_d = HALT;
      end else begin
        stat_d = 2'd0;
      end
      if ((bus.icode_i == I_OPL) && !illegal) begin
        cc_d = {zf, sf, of};
      end
    end else if (bus.flush_i || bus.out_ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RUN;
      valid_q <= 1'b0;
      icode_q <= '0;
      ifun_q  <= '0;
      vale_q  <= '0;
      cnd_q   <= 1'b0;
      cc_q    <= CC_RESET;
      stat_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      icode_q <= icode_d;
      ifun_q  <= ifun_d;
      vale_q  <= vale_d;
      cnd_q   <= cnd_d;
      cc_q    <= cc_d;
      stat_q  <= stat_d;
    end
  end

  assign bus.in_ready_o  = in_ready;
  assign bus.out_valid_o = valid_q;
  assign bus.icode_o     = icode_q;
  assign bus.ifun_o      = ifun_q;
  assign bus.valE_o      = vale_q;
  assign bus.cnd_o       = cnd_q;
  assign bus.cc_o        = cc_q;
  assign bus.stat_o      = stat_q;
  assign bus.halted_o    = (state_q == HALT);

endmodule

// File: tb/tb_ex_ctrl.sv
module tb_ex_ctrl;

  logic clk;
  logic rst_n;

  ex_ctrl_if #(.WIDTH(32)) bus ();

  ex_ctrl #(.WIDTH(32), .CC_RESET(3'b100)) dut (
    .clk (clk),
    .rst (rst_n),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]  icode;
    logic [7:0]  ifun;
    logic [31:0] vale;
    logic        cnd;
    logic [1:0]  stat;
  } exp_t;

  exp_t exp_q[$];

  int   n_checks = 0;
  int   n_errors = 0;

  logic       m_valid;
  logic       m_halt;
  logic [2:0] m_cc;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic cond_f(input logic [7:0] f, input logic [2:0] cc);
    logic zf, sf, of;
    zf = cc[2]; sf = cc[1]; of = cc[0];
    case (f)
      8'd0: return 1'b1;
      8'd1: return (sf ^ of) | zf;
      8'd2: return sf ^ of;
      8'd3: return zf;
      8'd4: return !zf;
      8'd5: return !(sf ^ of);
      8'd6: return !(sf ^ of) && !zf;
      default: return 1'b0;
    endcase
  endfunction

  task automatic set_in(input logic v, input logic [7:0] ic, input logic [7:0] fn,
                        input logic [31:0] a, input logic [31:0] b, input logic [31:0] e);
    bus.in_valid_i = v;
    bus.icode_i    = ic;
    bus.ifun_i     = fn;
    bus.valA_i     = a;
    bus.valB_i     = b;
    bus.valE_i     = e;
  endtask

  task automatic check_head(input string tag);
    exp_t h;
    if (exp_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 64'd1, 64'd0);
    end else begin
      h = exp_q[0];
      chk({tag, "_icode"}, 64'(bus.icode_o), 64'(h.icode));
      chk({tag, "_ifun"},  64'(bus.ifun_o),  64'(h.ifun));
      chk({tag, "_valE"},  64'(bus.valE_o),  64'(h.vale));
      chk({tag, "_cnd"},   64'(bus.cnd_o),   64'(h.cnd));
      chk({tag, "_stat"},  64'(bus.stat_o),  64'(h.stat));
    end
  endtask

  // One clock cycle with the inputs already driven: check ready, model, advance, check state.
  task automatic tick(input string tag);
    logic exp_rdy, acc, ill, ofl;
    logic [7:0] ic, fn;
    logic [31:0] a, b, e;
    exp_t x;
    #1;
    ic = bus.icode_i; fn = bus.ifun_i; a = bus.valA_i; b = bus.valB_i; e = bus.valE_i;
    exp_rdy = !m_halt && !bus.flush_i && (!m_valid || bus.out_ready_i);
    chk({tag, "_in_ready"}, 64'(bus.in_ready_o), 64'(exp_rdy));
    acc = bus.in_valid_i && exp_rdy;
    if (m_valid && bus.out_ready_i && !bus.flush_i) begin
      check_head({tag, "_consume"});
      void'(exp_q.pop_front());
    end else if (m_valid && bus.flush_i) begin
      void'(exp_q.pop_front());
    end
    if (acc) begin
      ill = (ic > 8'h0B) || (ic == 8'h06 && fn > 8'd3) ||
            ((ic == 8'h02 || ic == 8'h07) && fn > 8'd6);
      x.icode = ic; x.ifun = fn; x.vale = e;
      x.cnd   = (ic == 8'h02 || ic == 8'h07) ? cond_f(fn, m_cc) : 1'b0;
      x.stat  = ill ? 2'd2 : (ic == 8'h00 ? 2'd1 : 2'd0);
      exp_q.push_back(x);
      if (ill || ic == 8'h00) m_halt = 1'b1;
      if (ic == 8'h06 && !ill) begin
        if (fn == 8'd0)      ofl = (a[31] == b[31]) && (e[31] != a[31]);
        else if (fn == 8'd1) ofl = (a[31] != b[31]) && (e[31] != b[31]);
        else                 ofl = 1'b0;
        m_cc = {(e == 32'd0), e[31], ofl};
      end
      m_valid = 1'b1;
    end else if (bus.flush_i || bus.out_ready_i) begin
      m_valid = 1'b0;
    end
    @(posedge clk);
    #1;
    chk({tag, "_out_valid"}, 64'(bus.out_valid_o), 64'(m_valid));
    chk({tag, "_halted"},    64'(bus.halted_o),    64'(m_halt));
    chk({tag, "_cc"},        64'(bus.cc_o),        64'(m_cc));
    if (m_valid) check_head({tag, "_hold"});
  endtask

  task automatic async_reset(input string tag);
    rst_n = 1'b0;
    #1;
    chk({tag, "_out_valid"}, 64'(bus.out_valid_o), 64'd0);
    chk({tag, "_icode"},     64'(bus.icode_o),     64'd0);
    chk({tag, "_ifun"},      64'(bus.ifun_o),      64'd0);
    chk({tag, "_valE"},      64'(bus.valE_o),      64'd0);
    chk({tag, "_cnd"},       64'(bus.cnd_o),       64'd0);
    chk({tag, "_stat"},      64'(bus.stat_o),      64'd0);
    chk({tag, "_cc"},        64'(bus.cc_o),        64'h4);
    chk({tag, "_halted"},    64'(bus.halted_o),    64'd0);
    m_valid = 1'b0; m_halt = 1'b0; m_cc = 3'b100;
    exp_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    bus.flush_i = 1'b0;
    bus.out_ready_i = 1'b1;
    set_in(1'b0, 8'h00, 8'h00, 32'd0, 32'd0, 32'd0);
    m_valid = 1'b0; m_halt = 1'b0; m_cc = 3'b100;
    repeat (2) @(posedge clk);
    #1;
    async_reset("reset");

    // addl overflow into the sign bit
    set_in(1'b1, 8'h06, 8'h00, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000);
    tick("addl");
    chk("addl_cc_const", 64'(bus.cc_o), 64'h3);
    chk("addl_valE_const", 64'(bus.valE_o), 64'h8000_0000);

    // subl equal operands, then jle / jg
    set_in(1'b1, 8'h06, 8'h01, 32'd5, 32'd5, 32'd0);
    tick("subl");
    set_in(1'b1, 8'h07, 8'h01, 32'd0, 32'd0, 32'h100);
    tick("jle");
    chk("jle_cnd_const", 64'(bus.cnd_o), 64'd1);
    set_in(1'b1, 8'h07, 8'h06, 32'd0, 32'd0, 32'h200);
    tick("jg");
    chk("jg_cnd_const", 64'(bus.cnd_o), 64'd0);
    chk("jg_cc_const", 64'(bus.cc_o), 64'h4);

    // stall: register full, memory not ready; the pending OPL must not touch CC
    bus.out_ready_i = 1'b0;
    set_in(1'b1, 8'h06, 8'h00, 32'd1, 32'd0, 32'd1);
    for (int i = 0; i < 5; i++) tick("stall");
    chk("stall_cc_const", 64'(bus.cc_o), 64'h4);

    // release: back-to-back accepts with no bubble
    bus.out_ready_i = 1'b1;
    tick("b2b_add");
    set_in(1'b1, 8'h06, 8'h03, 32'hF0F0_0000, 32'hF0F0_0000, 32'd0);
    tick("b2b_xor");
    set_in(1'b1, 8'h02, 8'h03, 32'd7, 32'd0, 32'd7);
    tick("b2b_cmove");
    chk("cmove_cnd_const", 64'(bus.cnd_o), 64'd1);
    set_in(1'b1, 8'h06, 8'h01, 32'd1, 32'h8000_0000, 32'h7FFF_FFFF);
    tick("b2b_sub_of");
    chk("sub_of_cc_const", 64'(bus.cc_o), 64'h1);

    // flush with a full register and a valid addl presented
    bus.flush_i = 1'b1;
    set_in(1'b1, 8'h06, 8'h00, 32'd0, 32'd0, 32'd0);
    tick("flush");
    chk("flush_valid_const", 64'(bus.out_valid_o), 64'd0);
    chk("flush_cc_const", 64'(bus.cc_o), 64'h1);
    bus.flush_i = 1'b0;

    // illegal OPL: INS status, halt, CC unchanged
    set_in(1'b1, 8'h06, 8'h04, 32'd0, 32'd0, 32'd0);
    tick("ins");
    chk("ins_stat_const", 64'(bus.stat_o), 64'd2);
    chk("ins_halted_const", 64'(bus.halted_o), 64'd1);
    bus.out_ready_i = 1'b0;
    tick("ins_hold");
    bus.out_ready_i = 1'b1;
    tick("ins_drain");
    tick("ins_idle");
    async_reset("rst_after_ins");

    // illegal icode beyond the table
    set_in(1'b1, 8'h0C, 8'h00, 32'd0, 32'd0, 32'h55);
    tick("bad_icode");
    chk("bad_icode_stat_const", 64'(bus.stat_o), 64'd2);
    async_reset("rst_after_bad");

    // HALT: stays halted with input offered, then async reset mid-operation
    set_in(1'b1, 8'h06, 8'h00, 32'd2, 32'd3, 32'd5);
    tick("pre_halt_add");
    set_in(1'b1, 8'h00, 8'h00, 32'd0, 32'd0, 32'd0);
    tick("halt");
    chk("halt_stat_const", 64'(bus.stat_o), 64'd1);
    bus.out_ready_i = 1'b0;
    set_in(1'b1, 8'h06, 8'h00, 32'd0, 32'd0, 32'd0);
    for (int i = 0; i < 3; i++) tick("halted");
    chk("halted_ready_const", 64'(bus.in_ready_o), 64'd0);
    async_reset("rst_mid_op");

    set_in(1'b0, 8'h00, 8'h00, 32'd0, 32'd0, 32'd0);
    bus.out_ready_i = 1'b1;
    tick("post_reset");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
